serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, operand width in bits (legal range 2..32).
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide port start  input  1  request a new addition; sampled on rising clk.
REQ-005 SHALL provide port a  input  WIDTH  augend, unsigned or two's complement.
REQ-006 SHALL provide port b  input  WIDTH  addend.
REQ-007 SHALL provide port cin  input  1  carry-in added at bit 0.
REQ-008 SHALL provide port busy  output  1  high while bits are being processed.
REQ-009 SHALL provide port done  output  1  one-cycle pulse; sum/cout newly valid.
REQ-010 SHALL provide port sum  output  WIDTH  registered result.
REQ-011 SHALL provide port cout  output  1  registered carry out of bit WIDTH-1.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 IDLE: start=1 at edge E0 -> latch a, b into internal shift registers and cin into the carry flop, clear bit counter, go to SHIFT; start=0 -> stay IDLE.
REQ-014 SHIFT: each edge SHALL compute one result bit LSB-first via a single full adder (s = ai^bi^c, c' = ai&bi | c&(ai^bi)), shift operands right, shift s into result register MSB, update carry flop, increment counter.
REQ-015 SHIFT SHALL last exactly WIDTH edges (E1..E_WIDTH); at E_WIDTH go to DONE and load sum and cout from the result register and carry.
REQ-016 DONE SHALL last exactly one cycle with done=1; at E_WIDTH+1 go to IDLE, or to SHIFT if start=1 (back-to-back accepted, same latching as REQ-013).
REQ-017 Latency: done SHALL be high in the cycle after E_WIDTH, i.e. WIDTH+1 edges after start is sampled.
REQ-018 busy SHALL be 1 exactly while state is SHIFT; done SHALL be 1 exactly while state is DONE.
REQ-019 start SHALL be ignored while in SHIFT; a, b, cin SHALL be ignored except at the accepting edge.
REQ-020 sum and cout SHALL hold their last value until the next DONE entry, including across ignored starts.
REQ-021 Result SHALL equal {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), for all inputs.

Reset
REQ-022 rst=1 at an edge SHALL force state IDLE, busy=0, done=0, sum=0, cout=0, carry=0, counter=0, operand/result shift registers=0.
REQ-023 rst SHALL take priority over start and over any FSM transition.
REQ-024 rst during SHIFT SHALL abort the operation; no done pulse SHALL follow.

Configuration
REQ-025 Macro SERIAL_ADDER_OVF_EN defined: SHALL add port ovf  output  1, registered with sum/cout, equal to (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), reset 0, held per REQ-020.
REQ-026 Macro SERIAL_ADDER_OVF_EN undefined: ovf port and its logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=4)
REQ-027 a=5, b=3, cin=0, start 1 cycle -> busy high 4 cycles, done 5 edges after start, sum=8, cout=0, ovf=1 (if enabled).
REQ-028 a=15, b=1, cin=0 -> sum=0, cout=1, ovf=0; a=0, b=0, cin=1 -> sum=1, cout=0.
REQ-029 start=1 held continuously with a=7,b=7 then a=2,b=2 changed during SHIFT -> first result sum=14 cout=0, input change ignored; DONE re-accepts start, second result sum=4.
REQ-030 rst asserted at 2nd SHIFT edge of a=9,b=9 -> next cycle IDLE, busy=0, sum=0, cout=0, no done pulse ever.
REQ-031 exhaustive sweep all a, b, cin (512 ops, back-to-back) -> every {cout,sum} matches a+b+cin; done exactly once per accepted start.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder processes a WIDTH-bit a+b+cin, LSB first, one bit per clock.
// Latency: done pulses WIDTH+1 edges after start is sampled; sum/cout/ovf registered and held until the next done.
// Backpressure: start is accepted only in IDLE or DONE (back-to-back); ignored while busy.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   start       request a new addition (a, b, cin latched at the accepting edge)
//   a, b, cin   operands and carry-in
//   busy        high while bits are being processed (SHIFT)
//   done        one-cycle pulse, sum/cout newly valid (DONE)
//   sum, cout   registered result and carry out of bit WIDTH-1
//   ovf         signed overflow, present only when SERIAL_ADDER_OVF_EN is defined
//
// Optional feature macro: SERIAL_ADDER_OVF_EN
module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opa, opb, res;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             accept;
    logic             last_bit;
    logic             fa_s, fa_c;

    // Single full adder on the current LSBs of the operand shift registers.
    assign fa_s     = opa[0] ^ opb[0] ^ carry;
    assign fa_c     = (opa[0] & opb[0]) | (carry & (opa[0] ^ opb[0]));
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand/result shift registers, carry, counter, output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (accept) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            opa   <= opa >> 1;
            opb   <= opb >> 1;
            // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
            res   <= {fa_s, res[WIDTH-1:1]};
            carry <= fa_c;
            cnt   <= cnt + 1'b1;
            if (last_bit) begin
                sum  <= {fa_s, res[WIDTH-1:1]};
                cout <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                // carry still holds the carry into the MSB at this edge
                ovf  <= carry ^ fa_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic             busy, done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int checks   = 0;
    int failures = 0;
    int donecnt  = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count done pulses as seen at each rising edge.
    always @(posedge clk) begin
        if (done === 1'b1) donecnt = donecnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-pulse start, full timing check, then verify the result holds.
    task automatic run_op(input string tag, input logic [3:0] va, input logic [3:0] vb,
                          input logic vc, input logic [3:0] esum, input logic ecout,
                          input logic eovf);
        a = va; b = vb; cin = vc; start = 1'b1;
        tick();                                   // E0: accepted
        start = 1'b0;
        a = ~va; b = ~vb; cin = ~vc;              // must be ignored from here on
        chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
        for (int i = 1; i < WIDTH; i++) begin
            tick();
            chk({tag, "_busy_shift"}, 32'({busy, done}), 32'b10);
        end
        tick();                                   // E_WIDTH: now in DONE
        chk({tag, "_done"}, 32'({busy, done}), 32'b01);
        chk({tag, "_sum"}, 32'(sum), 32'(esum));
        chk({tag, "_cout"}, 32'(cout), 32'(ecout));
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
`else
        if (eovf === 1'bx) $display("unexpected X ovf expectation");
`endif
        tick();
        chk({tag, "_idle_hold"}, 32'({busy, done, cout, sum}), 32'({1'b0, 1'b0, ecout, esum}));
    endtask

    initial begin
        logic [4:0] exp5;
        int         saw_done;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick();
        tick();
        chk("reset_state", 32'({busy, done, cout, sum}), 32'd0);
        rst = 1'b0;
        start = 1'b1; a = 4'd9; b = 4'd9;
        rst = 1'b1;                               // reset beats start
        tick();
        chk("reset_prio", 32'({busy, done}), 32'd0);
        rst = 1'b0; start = 1'b0;
        tick();

        run_op("op5p3",  4'd5,  4'd3, 1'b0, 4'd8, 1'b0, 1'b1);
        run_op("op15p1", 4'd15, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0);
        run_op("op0c1",  4'd0,  4'd0, 1'b1, 4'd1, 1'b0, 1'b0);
        run_op("op7p9c", 4'd7,  4'd9, 1'b1, 4'd1, 1'b1, 1'b0);

        // Held start, inputs changed mid-operation, back-to-back re-accept from DONE.
        start = 1'b1; a = 4'd7; b = 4'd7; cin = 1'b0;
        tick();
        a = 4'd2; b = 4'd2;
        for (int i = 1; i < WIDTH; i++) tick();
        tick();
        chk("b2b_first_done", 32'(done), 32'd1);
        chk("b2b_first_res", 32'({cout, sum}), 32'({1'b0, 4'd14}));
        tick();                                   // re-accepted from DONE
        chk("b2b_reaccept_busy", 32'(busy), 32'd1);
        start = 1'b0;
        for (int i = 1; i < WIDTH; i++) tick();
        tick();
        chk("b2b_second_done", 32'(done), 32'd1);
        chk("b2b_second_res", 32'({cout, sum}), 32'({1'b0, 4'd4}));
        tick();

        // Reset at the second SHIFT edge aborts; no done pulse afterwards.
        start = 1'b1; a = 4'd9; b = 4'd9; cin = 1'b0;
        tick();                                   // E0
        start = 1'b0;
        tick();                                   // E1
        rst = 1'b1;
        tick();                                   // E2 with reset
        rst = 1'b0;
        chk("abort_state", 32'({busy, done, cout, sum}), 32'd0);
        donecnt = 0;
        for (int i = 0; i < 10; i++) tick();
        chk("abort_no_done", 32'(donecnt), 32'd0);

        // Exhaustive back-to-back sweep with start held high.
        donecnt = 0;
        saw_done = 0;
        start = 1'b1;
        for (int i = 0; i < 512; i++) begin
            a = i[3:0]; b = i[7:4]; cin = i[8];
            exp5 = 5'(i[3:0]) + 5'(i[7:4]) + 5'(i[8]);
            tick();                               // accept
            for (int k = 1; k < WIDTH; k++) tick();
            tick();
            if (done !== 1'b1) saw_done++;
            checks++;
            assert ({cout, sum} === exp5) else begin
                failures++;
                $error("FAIL sweep a=%0d b=%0d cin=%0d observed=%0d expected=%0d",
                       i[3:0], i[7:4], i[8], {cout, sum}, exp5);
            end
        end
        start = 1'b0;
        tick();
        chk("sweep_done_missing", 32'(saw_done), 32'd0);
        chk("sweep_done_count", 32'(donecnt), 32'd512);
        chk("sweep_final_idle", 32'({busy, done}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
